// File: rtl/iiitb_sqd_ser.sv
// MSB-first serializer feeding a sequence detector; one frame per accepted word.
// Define SQD_SER_PARITY_EN to append an even-parity bit to every frame.
module iiitb_sqd_ser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             din,
  output logic             dout_valid,
  output logic [7:0]       frames
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SQD_SER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

`ifdef SQD_SER_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic             par_r;
`endif

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] sreg_r;
  logic [CW-1:0]    cnt_r;
  logic [7:0]       frames_r;
  logic             accept_s;
  logic             last_s;

  assign accept_s = in_valid & in_ready;
  assign frames   = frames_r;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = SHIFT;
        else          next_state_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r != CNT_ZERO) next_state_s = SHIFT;
`ifdef SQD_SER_PARITY_EN
        else                   next_state_s = PARITY;
`else
        else if (accept_s)     next_state_s = SHIFT;
        else                   next_state_s = IDLE;
`endif
      end
`ifdef SQD_SER_PARITY_EN
      PARITY: begin
        if (accept_s) next_state_s = SHIFT;
        else          next_state_s = IDLE;
      end
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; the line is forced low whenever no frame bit is on it
  always_comb begin
    din        = 1'b0;
    dout_valid = 1'b0;
    in_ready   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        dout_valid = 1'b1;
        din        = sreg_r[WIDTH-1];
`ifdef SQD_SER_PARITY_EN
        in_ready   = 1'b0;
        last_s     = 1'b0;
`else
        in_ready   = (cnt_r == CNT_ZERO);
        last_s     = (cnt_r == CNT_ZERO);
`endif
      end
`ifdef SQD_SER_PARITY_EN
      PARITY: begin
        dout_valid = 1'b1;
        din        = par_r;
        in_ready   = 1'b1;
        last_s     = 1'b1;
      end
`endif
      default: begin
        din        = 1'b0;
        dout_valid = 1'b0;
        in_ready   = 1'b0;
        last_s     = 1'b0;
      end
    endcase
  end

  // Datapath: load on accept (only possible in IDLE or the final bit), else shift
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_r   <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
      frames_r <= 8'd0;
`ifdef SQD_SER_PARITY_EN
      par_r    <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        sreg_r <= in_data;
        cnt_r  <= LAST_IDX;
`ifdef SQD_SER_PARITY_EN
        par_r  <= even_parity(in_data);
`endif
      end else if ((state_r == SHIFT) && (cnt_r != CNT_ZERO)) begin
        sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
        cnt_r  <= cnt_r - CNT_ONE;
      end else begin
        sreg_r <= sreg_r;
        cnt_r  <= cnt_r;
      end
      if (last_s) frames_r <= frames_r + 8'd1;
      else        frames_r <= frames_r;
    end
  end

endmodule
